// File: rtl/projsel_pkg.sv
// Shared constants, state encoding and helpers for the Wishbone project-select controller.
package projsel_pkg;

    localparam int GUARD_W = 16;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ACTIVE = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_GUARD  = 2'd3;

    localparam int CTRL_IDX_W     = 5;
    localparam int CTRL_EN_BIT    = 8;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_ERR_BIT   = 1;
    localparam int STAT_IRQ_BIT   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic                  en;
        logic [CTRL_IDX_W-1:0] idx;
    } target_t;

    // Out-of-range indices yield all-zero so a bad target can never light two enables.
    function automatic logic [31:0] onehot(input logic [CTRL_IDX_W-1:0] idx, input int unsigned n);
        logic [31:0] v;
        v = 32'd0;
        if (32'(idx) < n) begin
            v[idx] = 1'b1;
        end else begin
            v = 32'd0;
        end
        return v;
    endfunction

endpackage

// File: rtl/wb_project_select_if.sv
// Wishbone slave-port bundle for the project-select controller (directions named from the slave side).
interface wb_project_select_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/projsel_guard_fsm.sv
// Guarded switch sequencer: drops all enables, counts the guard interval, then raises the target.
module projsel_guard_fsm
    import projsel_pkg::*;
#(
    parameter int NPROJ = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  target_t            target,
    input  logic [GUARD_W-1:0] guard,
    output logic               busy,
    output logic               done_pulse,
    output logic [NPROJ-1:0]   active
);

    state_e             state_r, state_s;
    logic [GUARD_W-1:0] cnt_r, cnt_s;
    target_t            tgt_r, tgt_s;
    logic [NPROJ-1:0]   active_r, active_s;
    logic               done_s;

    // Next-state, counter and enable-vector logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        tgt_s    = tgt_r;
        active_s = active_r;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    active_s = {NPROJ{1'b0}};
                    cnt_s    = guard;
                    tgt_s    = target;
                    state_s  = DRAIN;
                end else begin
                    state_s  = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_r == {GUARD_W{1'b0}}) begin
                    active_s = tgt_r.en ? NPROJ'(onehot(tgt_r.idx, NPROJ)) : {NPROJ{1'b0}};
                    done_s   = 1'b1;
                    state_s  = IDLE;
                end else begin
                    cnt_s    = cnt_r - {{(GUARD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                active_s = {NPROJ{1'b0}};
                state_s  = IDLE;
            end
        endcase
    end

    // State, counter, target and enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {GUARD_W{1'b0}};
            tgt_r    <= '{en: 1'b0, idx: {CTRL_IDX_W{1'b0}}};
            active_r <= {NPROJ{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            tgt_r    <= tgt_s;
            active_r <= active_s;
        end
    end

    assign busy       = (state_r == DRAIN);
    assign done_pulse = done_s;
    assign active     = active_r;

endmodule

// File: rtl/wb_project_select.sv
// Wishbone-mapped project-select controller: register file, STATUS bits and bus decode.
// Optional LA override inputs are compiled in with `define PROJSEL_LA_OVERRIDE_EN.
`ifdef FORMAL
module projsel_onehot_chk #(
    parameter int NPROJ = 32
) (
    input logic             clk,
    input logic             rst_n,
    input logic [NPROJ-1:0] active
);
    // The enable vector may never select more than one project.
    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(active));
        end
    end
endmodule
`endif

module wb_project_select
    import projsel_pkg::*;
#(
    parameter int          NPROJ         = 32,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter logic [15:0] GUARD_DEFAULT = 16'd8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_project_select_if.slave wbs,
`ifdef PROJSEL_LA_OVERRIDE_EN
    input  logic               la_ovr_en_i,
    input  logic [4:0]         la_ovr_idx_i,
`endif
    output logic [NPROJ-1:0]   active_o,
    output logic               switch_irq_o
);

    logic               ack_r;
    logic [31:0]        dat_r;
    target_t            ctrl_r, ctrl_s, new_ctrl_s, target_s;
    logic [GUARD_W-1:0] guard_r, guard_s;
    logic               err_r, err_s, irq_r, irq_s;
    logic               req_s, hit_s, wr_s;
    logic [1:0]         off_s;
    logic               ctrl_wr_s, stat_wr_s, guard_wr_s, idx_ok_s;
    logic               bus_start_s, ctrl_err_s, start_s;
    logic               busy_s, done_s;
    logic               ovr_block_s, ovr_start_s;
    target_t            ovr_tgt_s;
    logic [31:0]        rdata_s;
    logic               unused_bits_s;

    assign req_s      = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_r;
    assign hit_s      = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off_s      = wbs.wbs_adr_i[3:2];
    assign wr_s       = req_s & hit_s & wbs.wbs_we_i;
    assign ctrl_wr_s  = wr_s & (off_s == REG_CTRL) & wbs.wbs_sel_i[0];
    assign stat_wr_s  = wr_s & (off_s == REG_STATUS) & wbs.wbs_sel_i[0];
    assign guard_wr_s = wr_s & (off_s == REG_GUARD);
    assign idx_ok_s   = ({1'b0, wbs.wbs_dat_i[CTRL_IDX_W-1:0]} < 6'(NPROJ));

    assign new_ctrl_s.idx = wbs.wbs_dat_i[CTRL_IDX_W-1:0];
    assign new_ctrl_s.en  = wbs.wbs_sel_i[1] ? wbs.wbs_dat_i[CTRL_EN_BIT] : ctrl_r.en;

    // A bus switch is refused while a switch runs, the index is out of range, or the LA owns selection.
    assign bus_start_s = ctrl_wr_s & idx_ok_s & ~busy_s & ~ovr_block_s;
    assign ctrl_err_s  = ctrl_wr_s & ~bus_start_s;
    assign start_s     = bus_start_s | ovr_start_s;
    assign target_s    = bus_start_s ? new_ctrl_s : ovr_tgt_s;

`ifdef PROJSEL_LA_OVERRIDE_EN
    logic       ovr_en_q_r;
    logic [4:0] ovr_idx_q_r, ovr_pend_idx_r, ovr_pend_idx_s;
    logic       ovr_pend_r, ovr_pend_s, ovr_trig_s;

    assign ovr_block_s    = la_ovr_en_i;
    assign ovr_trig_s     = la_ovr_en_i & (~ovr_en_q_r | (la_ovr_idx_i != ovr_idx_q_r));
    assign ovr_start_s    = ovr_pend_r & ~busy_s & ~bus_start_s;
    assign ovr_pend_s     = la_ovr_en_i & (ovr_trig_s | (ovr_pend_r & ~ovr_start_s));
    assign ovr_pend_idx_s = ovr_trig_s ? la_ovr_idx_i : ovr_pend_idx_r;
    assign ovr_tgt_s      = '{en: 1'b1, idx: ovr_pend_idx_r};

    // Override edge/change detection and the held request that waits out a busy switch.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ovr_en_q_r     <= 1'b0;
            ovr_idx_q_r    <= 5'd0;
            ovr_pend_r     <= 1'b0;
            ovr_pend_idx_r <= 5'd0;
        end else begin
            ovr_en_q_r     <= la_ovr_en_i;
            ovr_idx_q_r    <= la_ovr_idx_i;
            ovr_pend_r     <= ovr_pend_s;
            ovr_pend_idx_r <= ovr_pend_idx_s;
        end
    end
`else
    assign ovr_block_s = 1'b0;
    assign ovr_start_s = 1'b0;
    assign ovr_tgt_s   = '{en: 1'b0, idx: {CTRL_IDX_W{1'b0}}};
`endif

    // Register-file next values; a status set on the same edge as its W1C wins.
    always_comb begin
        ctrl_s        = bus_start_s ? new_ctrl_s : ctrl_r;
        guard_s[7:0]  = (guard_wr_s & wbs.wbs_sel_i[0]) ? wbs.wbs_dat_i[7:0]  : guard_r[7:0];
        guard_s[15:8] = (guard_wr_s & wbs.wbs_sel_i[1]) ? wbs.wbs_dat_i[15:8] : guard_r[15:8];
        err_s         = ctrl_err_s | (err_r & ~(stat_wr_s & wbs.wbs_dat_i[STAT_ERR_BIT]));
        irq_s         = done_s     | (irq_r & ~(stat_wr_s & wbs.wbs_dat_i[STAT_IRQ_BIT]));
    end

    // Read-data mux; anything outside the window reads as zero.
    always_comb begin
        rdata_s = 32'd0;
        if (hit_s) begin
            case (off_s)
                REG_CTRL:   rdata_s = {23'd0, ctrl_r.en, 3'd0, ctrl_r.idx};
                REG_ACTIVE: rdata_s = 32'(active_o);
                REG_STATUS: rdata_s = {29'd0, irq_r, err_r, busy_s};
                REG_GUARD:  rdata_s = {16'd0, guard_r};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Bus response and register-file state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_r   <= 1'b0;
            dat_r   <= 32'd0;
            ctrl_r  <= '{en: 1'b0, idx: {CTRL_IDX_W{1'b0}}};
            guard_r <= GUARD_DEFAULT;
            err_r   <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            ack_r   <= req_s;
            dat_r   <= req_s ? rdata_s : 32'd0;
            ctrl_r  <= ctrl_s;
            guard_r <= guard_s;
            err_r   <= err_s;
            irq_r   <= irq_s;
        end
    end

    projsel_guard_fsm #(
        .NPROJ (NPROJ)
    ) u_guard_fsm (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .start      (start_s),
        .target     (target_s),
        .guard      (guard_r),
        .busy       (busy_s),
        .done_pulse (done_s),
        .active     (active_o)
    );

`ifdef FORMAL
    projsel_onehot_chk #(
        .NPROJ (NPROJ)
    ) u_onehot_chk (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .active (active_o)
    );
`endif

    assign unused_bits_s  = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};
    assign wbs.wbs_ack_o  = ack_r;
    assign wbs.wbs_dat_o  = dat_r;
    assign switch_irq_o   = irq_r;

endmodule

// File: doc/wb_project_select.md
Name: wb_project_select

Overview:
- Wishbone-mapped project-select controller. It generates the one-hot `active` vector that the user-project wrapper fans out to its instantiated projects.
- It replaces raw logic-analyzer driving of `active` with a guarded switch sequence: drop all enables, wait a programmable guard interval, then assert the new one.
- Guarantees `active_o` is never more than one-hot, including during a switch.
- Sits between the Caravel Wishbone slave port and the wrapper's `active` net.

Parameters:
- NPROJ, 32, number of selectable projects (1..32); width of `active_o`.
- BASE_ADDR, 32'h3000_0000, register window base; decode on `adr[31:4]`.
- GUARD_DEFAULT, 16'd8, reset value of the GUARD register.

Ports:
- wb_clk_i  in  1  Wishbone/system clock.
- wb_rst_ni  in  1  reset; one clock; asynchronous, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- active_o  out  NPROJ  one-hot/zero project enable.
- switch_irq_o  out  1  level interrupt = IRQ_PEND bit.

Behaviour:
- Register map (offset, fields):
  - 0x0 CTRL: [4:0] idx, [8] en; R/W; read returns last accepted value.
  - 0x4 ACTIVE: read-only mirror of `active_o`, zero-extended.
  - 0x8 STATUS: [0] busy (RO), [1] err (W1C), [2] irq_pend (W1C).
  - 0xC GUARD: [15:0] guard cycles, R/W.
- Writes are byte-masked by `wbs_sel_i`. A CTRL write takes effect only if `sel[0]` is set; `en` is updated only if `sel[1]` is set.
- Bus handshake:
  - Request = `stb & cyc & !ack`.
  - `ack` is registered: high exactly one cycle, the cycle after the request is sampled. No back-to-back acks.
  - `wbs_dat_o` is valid with `ack` and is 0 otherwise.
  - Addresses outside the window are still acked; they read 0 and writes are ignored.
- FSM states IDLE and DRAIN; `busy = (state == DRAIN)`.
- IDLE + CTRL write with `idx < NPROJ`, on sampling edge E0:
  - `active_o <= 0`, `cnt <= GUARD`, target latched, state <= DRAIN.
- DRAIN, each edge:
  - If `cnt == 0`: `active_o <= en ? onehot(idx) : 0`, `irq_pend <= 1`, state <= IDLE.
  - Otherwise `cnt <= cnt - 1`.
- Latency: new `active_o` is visible after edge E0+GUARD+1. GUARD=0 gives a single zero cycle.
- CTRL write with `idx >= NPROJ`: `err <= 1`; CTRL and `active_o` unchanged; no switch.
- CTRL write while busy: dropped; `err <= 1`; the in-flight switch completes unchanged.
- GUARD write while busy: updates the register only; the running `cnt` is unaffected.
- Simultaneous W1C and set of the same STATUS bit on one edge: set wins.
- Reset (asynchronous, any state) returns:
  - `active_o = 0`, state = IDLE, `cnt = 0`, CTRL = 0, GUARD = GUARD_DEFAULT.
  - STATUS = 0, `wbs_ack_o = 0`, `wbs_dat_o = 0`, `switch_irq_o = 0`.
- Invariant: `$onehot0(active_o)` on every cycle; asserted under FORMAL.

Optional Feature:
- Macro: PROJSEL_LA_OVERRIDE_EN.
- When defined:
  - Adds inputs `la_ovr_en_i` (1 bit) and `la_ovr_idx_i` (5 bits).
  - While `la_ovr_en_i` is high, a rise of `la_ovr_en_i` or a change of `la_ovr_idx_i` (registered compare) triggers a switch to `{en=1, idx=la_ovr_idx_i}` through the same DRAIN sequence.
  - While `la_ovr_en_i` is high, bus CTRL writes are rejected with `err`.
  - An override request arriving while busy is held and retried on return to IDLE.
  - A fall of `la_ovr_en_i` leaves `active_o` unchanged.
- When undefined: these ports are absent and selection is bus-only.

Decomposition:
- projsel_pkg holds:
  - register offset localparams and field bit positions;
  - the state enum {IDLE, DRAIN};
  - the GUARD width constant (16);
  - a `onehot(idx, n)` function.
- One sub-module, projsel_guard_fsm, holds the FSM, guard counter and `active_o` register.
  - Inputs: `start`, `target`, `guard`.
  - Outputs: `busy`, `done_pulse`, `active`.
- The top level holds the Wishbone decode, regfile and STATUS bits.

Test Plan:
1. Reset, then read all four registers -> CTRL=0, ACTIVE=0, STATUS=0, GUARD=8, `switch_irq_o=0`.
2. Write CTRL=0x103 with GUARD=8 -> ack 1 cycle after request; `active_o=0` for 9 cycles; then `active_o=32'h8`, irq_pend=1, `switch_irq_o=1`. W1C 0x4 to STATUS clears the irq.
3. GUARD=0, CTRL=0x105, then CTRL=0x102 written during DRAIN -> second write acked, err=1, `active_o` ends at `32'h20`. Write 0x2 to STATUS clears err.
4. NPROJ=4, write CTRL=0x107 -> err=1, `active_o` unchanged, busy stays 0.
5. Assert `wb_rst_ni` low mid-DRAIN (cnt=3) -> `active_o=0` immediately (asynchronous). After release, state is IDLE and GUARD=8.
6. With PROJSEL_LA_OVERRIDE_EN: `la_ovr_en_i=1`, `la_ovr_idx_i=2` -> `active_o=4` after GUARD+1 cycles; bus write CTRL=0x101 -> err=1, `active_o` stays 4.
